ysyx_25040111_pcgen: RTL
========================

# ysyx_25040111_pcgen

Parametrised PC generator for the fetch stage. It replaces the single-register PC unit with a DEPTH-entry queue of speculative sequential fetch addresses and a valid/ready handshake toward the IFU. A single redirect port with four target modes (branch, jalr, mret, trap) flushes the queue and retags the stream with a new epoch. Downstream stages use the epoch bit to discard instructions fetched from stale PCs.

## Interface
- `XLEN`, 32: address width.
- `RESET_PC`, `32'h8000_0000` (`32'h3000_0000` when `RUNSOC` is defined): first PC issued after reset.
- `DEPTH`, 4: queue entries. Power of two, ≥2.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `redir_valid`  in  1  redirect request this cycle.
- `redir_mode`  in  2  target select: 00 `redir_pc+redir_imm`; 01 `(redir_rs1+redir_imm)&~1`; 10 `mret_addr`; 11 `trap_vec`.
- `redir_pc`  in  XLEN  PC of the redirecting instruction.
- `redir_rs1`  in  XLEN  rs1 value (jalr).
- `redir_imm`  in  XLEN  sign-extended immediate.
- `mret_addr`  in  XLEN  mepc value.
- `trap_vec`  in  XLEN  mtvec value.
- `out_valid`  out  1  queue head valid.
- `out_ready`  in  1  IFU accepts head.
- `out_pc`  out  XLEN  queue head PC.
- `out_epoch`  out  1  epoch tag of head.
- `occupancy`  out  $clog2(DEPTH)+1  entries held.

## Operation
- State: next-fetch pointer `npc`, current `epoch` bit, and a FIFO of {pc, epoch} with head/tail pointers and a count.
- Push: when `redir_valid`=0 and (count<DEPTH or pop this cycle), push {npc, epoch} and set npc ← npc+4.
- Pop: fires on `out_valid & out_ready`. The head advances.
- Redirect (`redir_valid`=1):
  - Compute the target per `redir_mode`. Mode 01 clears bit 0; other modes pass the target unmodified.
  - Clear the queue (count←0, head=tail).
  - Set npc ← target and toggle epoch.
  - No push occurs that cycle.
- Priority: reset > redirect > push/pop. A pop coinciding with a redirect completes its handshake; the entry is consumed and the flush then applies.
- Arithmetic: all sums are XLEN bits, modulo 2^XLEN. npc `FFFF_FFFC`+4 wraps to 0. No misalignment check is made; bit 1 of the target is passed through.
- Outputs are registered: `out_valid` = count≠0, `out_pc`/`out_epoch` = head entry, `occupancy` = count.

## Timing
- Reset (asynchronous assert, synchronous release by the clock domain):
  - npc=RESET_PC, epoch=0, count=0.
  - out_valid=0, out_pc=0, out_epoch=0, occupancy=0.
- First rising edge after release pushes RESET_PC. out_valid=1 and out_pc=RESET_PC from cycle 1.
- Redirect latency:
  - Redirect sampled at edge N.
  - Cycle N..N+1: out_valid=0 (one bubble).
  - Edge N+1 pushes the target. out_valid=1, out_pc=target, out_epoch toggled, from N+1.
- With out_ready held at 1 and no redirect, one PC is issued per cycle, incrementing by 4.
- Full (count=DEPTH) with out_ready=0: npc holds, the queue holds, and out_pc is stable.
- Full with a pop: push and pop happen in the same cycle; count stays at DEPTH.
- Back-to-back redirects on consecutive cycles:
  - Each one flushes and toggles epoch.
  - Only the last target is issued.
  - out_valid stays 0 until one cycle after the last redirect.
- Reset asserted mid-stream: all state is cleared immediately (asynchronously). Queued PCs are lost.

## Structure
- Shared package `ysyx_25040111_pkg`:
  - redirect mode encodings `REDIR_BR`/`REDIR_JALR`/`REDIR_MRET`/`REDIR_TRAP`.
  - `PC_RESET` constant selected by `RUNSOC`.
- Sub-module `ysyx_25040111_pcq`:
  - Parametrised synchronous FIFO, width XLEN+1, depth DEPTH.
  - Ports: push, pop, flush, full, empty, count.
- Top level holds the target mux/adder, npc, epoch and the push/redirect control.

## Test plan
- Reset with out_ready=0, DEPTH=4:
  - Cycle 1: out_pc=80000000.
  - After 4 cycles: occupancy=4; npc frozen at 80000010; out_pc stays 80000000.
- Continuous out_ready=1: issued PCs are 80000000, 80000004, 80000008…, one per cycle, epoch=0.
- Branch redirect (mode 00, redir_pc=80000008, imm=FFFFFFF8) at cycle 5:
  - Cycle 5: out_valid=0.
  - Cycle 6: out_pc=80000000, out_epoch=1.
  - All earlier queue entries discarded.
- jalr redirect (mode 01, rs1=80001001, imm=4): target 80001004 (bit 0 cleared); mret (mode 10, mepc=80002000) with pop in the same cycle: handshake completes, next out_pc=80002000.
- Wrap-around: trap redirect to FFFFFFF8 with out_ready=1 issues FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- Reset asserted mid-stream with a full queue: out_valid and occupancy drop to 0 without a clock edge; after release, out_pc=RESET_PC and epoch=0.

Source files
------------

// File: rtl/ysyx_25040111_pkg.sv
// Shared definitions for the fetch-stage PC generator.
package ysyx_25040111_pkg;

    // Redirect target select.
    typedef enum logic [1:0] {
        REDIR_BR   = 2'b00,
        REDIR_JALR = 2'b01,
        REDIR_MRET = 2'b10,
        REDIR_TRAP = 2'b11
    } redir_mode_e;

`ifdef RUNSOC
    localparam logic [31:0] PC_RESET = 32'h3000_0000;
`else
    localparam logic [31:0] PC_RESET = 32'h8000_0000;
`endif

endpackage

// File: rtl/ysyx_25040111_pcq.sv
// Synchronous FIFO of speculative fetch entries with single-cycle flush.
module ysyx_25040111_pcq #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Handshake qualification and pointer/count next state.
    always_comb begin
        full    = (count_q == FULL_CNT);
        empty   = (count_q == '0);
        do_pop  = pop & ~empty;
        // A full queue may still accept when its head leaves this cycle.
        do_push = push & (~full | do_pop) & ~flush;
        head_d  = head_q + PW'(do_pop);
        tail_d  = tail_q + PW'(do_push);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Storage and pointers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[tail_q] <= din;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign dout  = mem_q[head_q];
    assign count = count_q;

endmodule

// File: rtl/ysyx_25040111_pcgen.sv
// Fetch PC generator: sequential prefetch queue with epoch-tagged redirects.
module ysyx_25040111_pcgen
    import ysyx_25040111_pkg::*;
#(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(PC_RESET),
    parameter int unsigned    DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redir_valid,
    input  logic [1:0]             redir_mode,
    input  logic [XLEN-1:0]        redir_pc,
    input  logic [XLEN-1:0]        redir_rs1,
    input  logic [XLEN-1:0]        redir_imm,
    input  logic [XLEN-1:0]        mret_addr,
    input  logic [XLEN-1:0]        trap_vec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic                   out_epoch,
    output logic [$clog2(DEPTH):0] occupancy
);

    logic [XLEN-1:0] npc_q, npc_d;
    logic            epoch_q, epoch_d;
    logic [XLEN-1:0] target;
    logic            q_push, q_pop, q_full, q_empty;
    logic [XLEN:0]   q_dout;

    // Redirect target select; only jalr forces halfword alignment.
    always_comb begin
        target = redir_pc + redir_imm;
        unique case (redir_mode)
            REDIR_BR:   target = redir_pc + redir_imm;
            REDIR_JALR: target = (redir_rs1 + redir_imm) & ~XLEN'(1);
            REDIR_MRET: target = mret_addr;
            REDIR_TRAP: target = trap_vec;
        endcase
    end

    // Push/pop control and next npc/epoch; redirect overrides sequential advance.
    always_comb begin
        q_pop   = ~q_empty & out_ready;
        q_push  = ~redir_valid & (~q_full | q_pop);
        npc_d   = npc_q;
        epoch_d = epoch_q;
        if (redir_valid) begin
            npc_d   = target;
            epoch_d = ~epoch_q;
        end else if (q_push) begin
            npc_d = npc_q + XLEN'(4);
        end
    end

    // Next-fetch pointer and current epoch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            npc_q   <= RESET_PC;
            epoch_q <= 1'b0;
        end else begin
            npc_q   <= npc_d;
            epoch_q <= epoch_d;
        end
    end

    ysyx_25040111_pcq #(
        .WIDTH (XLEN + 1),
        .DEPTH (DEPTH)
    ) u_pcq (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .flush (redir_valid),
        .din   ({epoch_q, npc_q}),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (occupancy)
    );

    assign out_valid = ~q_empty;
    assign out_pc    = q_dout[XLEN-1:0];
    assign out_epoch = q_dout[XLEN];

endmodule
